// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: drives a single-word memory port with lane extraction,
// read-modify-write for sub-word stores, misalignment checks and a response timeout.
module lsu_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [23:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        mem_enable,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_RD_WAIT,
        WR_WAIT,
        RESP
    } state_e;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [23:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          bad_req;
    logic          tmo;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;
    logic [31:0]   merged;

    always_comb begin
        bad_req = 1'b0;
        unique case (req_size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = req_addr[0];
            2'b10:   bad_req = |req_addr[1:0];
            default: bad_req = 1'b1;
        endcase
    end

    assign tmo = (cnt_q == CNT_LAST);

    always_comb begin
        ld_byte = 8'h00;
        unique case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        unique case (size_q)
            2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Only the addressed lane is replaced; the rest comes from the read word.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b01) begin
            if (addr_q[1]) merged[31:16] = sdata_q[15:0];
            else           merged[15:0]  = sdata_q[15:0];
        end else begin
            unique case (addr_q[1:0])
                2'b00:   merged[7:0]   = sdata_q[7:0];
                2'b01:   merged[15:8]  = sdata_q[7:0];
                2'b10:   merged[23:16] = sdata_q[7:0];
                default: merged[31:24] = sdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    sdata_d = req_wdata;
                    cnt_d   = '0;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (bad_req) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = RD_WAIT;
                        en_d    = 1'b1;
                    end else if (req_size == 2'b10) begin
                        state_d = WR_WAIT;
                        en_d    = 1'b1;
                        wdata_d = req_wdata;
                    end else begin
                        state_d = RMW_RD_WAIT;
                        en_d    = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    state_d = RESP;
                    rdata_d = ld_data;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RMW_RD_WAIT: begin
                if (mem_ready) begin
                    state_d = WR_WAIT;
                    wdata_d = merged;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    state_d = RESP;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 24'h0;
            sdata_q <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = {addr_q[23:2], 2'b00};
    assign mem_we     = (state_q == WR_WAIT);
    assign mem_wdata  = wdata_q;
    assign mem_enable = en_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a small word-memory responder.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [23:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_enable;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:15];
    logic        hang = 1'b0;
    logic        inject = 1'b0;
    logic        pend = 1'b0;
    int          wr_cnt = 0;
    logic [23:0] en_addr = 24'h0;
    logic        en_we = 1'b0;
    logic [31:0] last_wdata = 32'h0;

    lsu_mem_initiator #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_enable(mem_enable),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Responder: ready one cycle after the enable, unless hung.
    always @(negedge clk) begin
        mem_ready = inject;
        if (pend) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr[5:2]];
            if (mem_we) begin
                mem[mem_addr[5:2]] = mem_wdata;
                last_wdata = mem_wdata;
                wr_cnt++;
            end
            pend = 1'b0;
        end
        if (mem_enable) begin
            en_addr = mem_addr;
            en_we   = mem_we;
            if (!hang) pend = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [23:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat, output int ens);
        logic got;
        int   w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        ens = 0;
        rd = 32'hDEADBEEF;
        err = 1'bx;
        while (!got && lat < 200) begin
            lat++;
            @(negedge clk);
            if (mem_enable) ens++;
            if (resp_valid) begin
                got = 1'b1;
                rd = resp_rdata;
                err = resp_err;
            end
        end
        chk("resp_seen", {31'h0, got}, 32'h1);
        @(negedge clk);
        chk("resp_pulse", {30'h0, resp_valid, req_ready}, 32'h1);
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat, ens, wr0;
    logic        bad;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h00408113;

        #3;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_outs", {29'h0, resp_valid, resp_err, mem_enable}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_addr", {8'h0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        #20 rst_n = 1'b1;

        xact(1'b0, 2'b10, 1'b0, 24'h000004, 32'h0, rd, err, lat, ens);
        chk("lw_rdata", rd, 32'h00408113);
        chk("lw_err", {31'h0, err}, 32'h0);
        chk("lw_lat", lat, 3);
        chk("lw_ens", ens, 1);
        chk("lw_maddr", {8'h0, en_addr}, 32'h000004);
        chk("lw_mwe", {31'h0, en_we}, 32'h0);

        xact(1'b0, 2'b00, 1'b0, 24'h000005, 32'h0, rd, err, lat, ens);
        chk("lb_rdata", rd, 32'hFFFFFF81);
        xact(1'b0, 2'b00, 1'b1, 24'h000005, 32'h0, rd, err, lat, ens);
        chk("lbu_rdata", rd, 32'h00000081);
        xact(1'b0, 2'b01, 1'b0, 24'h000006, 32'h0, rd, err, lat, ens);
        chk("lh_rdata", rd, 32'h00000040);
        xact(1'b0, 2'b01, 1'b1, 24'h000004, 32'h0, rd, err, lat, ens);
        chk("lhu_rdata", rd, 32'h00008113);
        xact(1'b0, 2'b01, 1'b0, 24'h000004, 32'h0, rd, err, lat, ens);
        chk("lh_neg", rd, 32'hFFFF8113);

        wr0 = wr_cnt;
        xact(1'b1, 2'b00, 1'b0, 24'h000005, 32'h000000AB, rd, err, lat, ens);
        chk("sb_err", {31'h0, err}, 32'h0);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_ens", ens, 2);
        chk("sb_lat", lat, 5);
        chk("sb_wdata", last_wdata, 32'h0040AB13);
        chk("sb_writes", wr_cnt - wr0, 1);
        xact(1'b0, 2'b10, 1'b0, 24'h000004, 32'h0, rd, err, lat, ens);
        chk("lw_after_sb", rd, 32'h0040AB13);

        xact(1'b1, 2'b10, 1'b0, 24'h000008, 32'hCAFEF00D, rd, err, lat, ens);
        chk("sw_lat", lat, 3);
        chk("sw_mem", mem[2], 32'hCAFEF00D);

        xact(1'b0, 2'b10, 1'b0, 24'h000002, 32'h0, rd, err, lat, ens);
        chk("mis_lw_err", {31'h0, err}, 32'h1);
        chk("mis_lw_rdata", rd, 32'h0);
        chk("mis_lw_lat", lat, 1);
        chk("mis_lw_ens", ens, 0);
        xact(1'b1, 2'b01, 1'b0, 24'h000003, 32'h1234, rd, err, lat, ens);
        chk("mis_sh_err", {31'h0, err}, 32'h1);
        chk("mis_sh_rdata", rd, 32'h0);
        chk("mis_sh_lat", lat, 1);
        chk("mis_sh_ens", ens, 0);
        xact(1'b0, 2'b11, 1'b0, 24'h000000, 32'h0, rd, err, lat, ens);
        chk("ill_err", {31'h0, err}, 32'h1);
        chk("ill_ens", ens, 0);

        hang = 1'b1;
        xact(1'b0, 2'b10, 1'b0, 24'h000000, 32'h0, rd, err, lat, ens);
        chk("tmo_err", {31'h0, err}, 32'h1);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_lat", lat, 65);
        chk("tmo_ens", ens, 1);
        #2 inject = 1'b1;
        @(negedge clk);
        #2 inject = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || mem_enable || !req_ready) bad = 1'b1;
        end
        chk("late_ready", {31'h0, bad}, 32'h0);
        hang = 1'b0;

        wr0 = wr_cnt;
        @(negedge clk);
        req_we = 1'b1;
        req_size = 2'b00;
        req_addr = 24'h000004;
        req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rd_en", {31'h0, mem_enable}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("mid_rst_flags", {28'h0, resp_valid, resp_err, mem_enable, mem_we}, 32'h0);
        chk("mid_rst_data", resp_rdata | mem_wdata | {8'h0, mem_addr}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_enable || resp_valid) bad = 1'b1;
        end
        chk("mid_rst_quiet", {31'h0, bad}, 32'h0);
        chk("mid_rst_nowrite", wr_cnt - wr0, 0);
        chk("mid_rst_mem", mem[1], 32'h0040AB13);
        xact(1'b0, 2'b10, 1'b0, 24'h000004, 32'h0, rd, err, lat, ens);
        chk("post_rst_lw", rd, 32'h0040AB13);
        chk("post_rst_err", {31'h0, err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator for the RV32 core: accepts byte/halfword/word load and store requests from the execute stage and drives the single-word memory controller port (address, write enable, write data, start strobe, ready). It performs lane extraction with sign/zero extension for loads and read-modify-write for sub-word stores. It also detects misaligned accesses and enforces a response timeout. It sits between the core datapath and the memory controller, as the initiator side of that interface.

## Interface
- TIMEOUT_CYCLES, 64: max cycles waited for mem_ready per memory transaction before error.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request strobe, sampled only when req_ready=1.
- req_ready  out  1  high exactly when FSM is IDLE, including while in reset.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend.
- req_addr  in  24  byte address.
- req_wdata  in  32  store data, right-aligned (bits [7:0] / [15:0] / [31:0] used).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or timeout.
- mem_addr  out  24  word-aligned byte address ([1:0]=00).
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write word.
- mem_enable  out  1  one-cycle start strobe per transaction.
- mem_ready  in  1  memory done; mem_rdata valid in the same cycle.
- mem_rdata  in  32  memory read word.

## Operation
- States: IDLE, RD_WAIT, RMW_RD_WAIT, WR_WAIT, RESP.
- IDLE: on req_valid, latch all req_* fields. Alignment check: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is illegal.
  - If the check fails: go to RESP with err=1. No mem_enable is issued.
  - Load → RD_WAIT.
  - Word store → WR_WAIT.
  - Byte/half store → RMW_RD_WAIT.
- Entering any *_WAIT state pulses mem_enable for exactly one cycle (the first cycle in that state).
  - mem_addr = {addr[23:2],2'b00}.
  - mem_we = 1 only in WR_WAIT.
  - mem_addr, mem_we and mem_wdata stay stable until mem_ready is sampled or a timeout occurs.
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1].
- RD_WAIT + mem_ready: extract the lane and extend it to 32 bits per req_unsigned → RESP, err=0.
- RMW_RD_WAIT + mem_ready: merge the store data into the addressed lane of mem_rdata, leaving other lanes unchanged. Load the merged word into mem_wdata → WR_WAIT (new mem_enable).
- WR_WAIT + mem_ready: → RESP, err=0, rdata=0.
- Timeout: a wait counter is cleared on each mem_enable and increments every wait cycle. Reaching TIMEOUT_CYCLES without mem_ready → RESP with err=1. If this occurs in RMW_RD_WAIT, no write is issued.
- RESP: resp_valid=1 for one cycle → IDLE.
- mem_ready while in IDLE or RESP is ignored.

## Timing
- Reset values:
  - State IDLE, req_ready=1.
  - resp_valid, resp_err, mem_enable, mem_we = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
  - Wait counter = 0.
- Reset asserted mid-transaction aborts immediately, with no resp_valid. The memory side may still complete; that mem_ready is ignored.
- Request accepted at edge E. mem_enable is high during cycle E+1.
- mem_ready sampled at edge R. resp_valid is high during the cycle after R (RESP).
- Load or word store: 2 cycles plus memory latency.
- Sub-word store: two memory transactions. Write mem_enable is high in the cycle after the read mem_ready.
- Misaligned or illegal request: resp_valid in cycle E+1, no memory activity.
- Back-to-back: req_ready returns high the cycle after resp_valid. The earliest next accept is the edge ending that cycle.
- Only one outstanding transaction at a time; there is no pipelining.

## Test plan
- Word load: memory word 0x04 = 0x00408113, lw @0x000004 → one mem_enable with mem_we=0, mem_addr=0x000004; resp_rdata=0x00408113, resp_err=0.
- Sub-word loads, same word:
  - lb @0x000005 → 0xFFFFFF81.
  - lbu @0x000005 → 0x00000081.
  - lh @0x000006 → 0x00000040.
  - lhu @0x000004 → 0x00008113.
- Byte store RMW: sb 0xAB @0x000005 over 0x00408113 → read transaction, then write transaction with mem_wdata=0x0040AB13; resp_err=0; a following lw returns 0x0040AB13.
- Misaligned: lw @0x000002 and sh @0x000003 → resp_valid one cycle after accept with resp_err=1, rdata=0, mem_enable never asserted.
- Timeout: memory model never asserts mem_ready, lw @0x000000 → resp_err=1 exactly 64 wait cycles after mem_enable. A late mem_ready injected afterwards is ignored.
- Reset mid-RMW: rst_n low during RMW_RD_WAIT → all outputs are 0 and req_ready=1 immediately; no write transaction is issued; after release, a new lw completes correctly.
